// File: rtl/ext_finish_pkg.sv
// Shared types, constants and helpers for the multi-channel simulation exit detector.
package ext_finish_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Field positions inside the status word {done, timeout, fail, code}
   function automatic int unsigned out_done_idx(input int unsigned code_w);
      return code_w + 2;
   endfunction

   function automatic int unsigned out_tmo_idx(input int unsigned code_w);
      return code_w + 1;
   endfunction

   function automatic int unsigned out_fail_idx(input int unsigned code_w);
      return code_w;
   endfunction

   // Exit code reported on a watchdog expiry: all ones at the configured width (up to 64)
   function automatic logic [63:0] timeout_code(input int unsigned code_w);
      return (64'd1 << code_w) - 64'd1;
   endfunction

   localparam string ANSI_GREEN = "\033[32m";
   localparam string ANSI_RED   = "\033[31m";
   localparam string ANSI_RESET = "\033[0m";

endpackage

// File: rtl/ext_finish_mc_if.sv
// Exit-request bus: packed per-channel {exit_req, exit_code} in, status word and finish strobe out.
interface ext_finish_mc_if #(
   parameter int unsigned NCH    = 2,
   parameter int unsigned CODE_W = 8
) ();
   logic [NCH*(CODE_W+1)-1:0] arg;
   logic [CODE_W+2:0]         out;
   logic                      finish;

   modport master (output arg, input out, input finish);
   modport slave  (input arg, output out, output finish);
endinterface

// File: rtl/ext_finish_chan.sv
// One exit channel: sticky exited flag plus the code latched on the first accepted request.
module ext_finish_chan #(
   parameter int unsigned CODE_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              capture_en,
   input  logic              exit_req,
   input  logic [CODE_W-1:0] exit_code,
   output logic              exited,
   output logic [CODE_W-1:0] code
);
   logic              exited_q;
   logic [CODE_W-1:0] code_q;

   // First accepted request wins; later ones on this channel are ignored
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         exited_q <= 1'b0;
         code_q   <= '0;
      end else if (capture_en && exit_req && !exited_q) begin
         exited_q <= 1'b1;
         code_q   <= exit_code;
      end
   end

   assign exited = exited_q;
   assign code   = code_q;
endmodule

// File: rtl/ext_finish_mc.sv
// Multi-channel exit detector: trigger, verdict encode, watchdog, drain delay and finish strobe.
module ext_finish_mc
   import ext_finish_pkg::*;
#(
   parameter int unsigned NCH          = 2,
   parameter int unsigned CODE_W       = 8,
   parameter int unsigned MODE_ALL     = 1,
   parameter int unsigned DRAIN_CYCLES = 16,
   parameter int unsigned TIMEOUT      = 0,
   parameter int unsigned TMR_W        = 32
) (
   input logic            CLK,
   input logic            RST,
   ext_finish_mc_if.slave bus
);
   localparam int unsigned       CW         = CODE_W + 1;
   localparam int unsigned       DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CODE_W-1:0] TO_CODE    = CODE_W'(timeout_code(CODE_W));
   localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   localparam logic [TMR_W-1:0]  WD_LAST    = TMR_W'(TIMEOUT - 1);
   localparam int unsigned       DONE_IDX   = out_done_idx(CODE_W);
   localparam int unsigned       TMO_IDX    = out_tmo_idx(CODE_W);
   localparam int unsigned       FAIL_IDX   = out_fail_idx(CODE_W);

   state_e              state_q, state_d;
   logic [NCH-1:0]      req, exited, exited_now;
   logic [CODE_W-1:0]   codes [NCH];
   logic                capture_en, trigger, wd_hit, fail_any;
   logic [CODE_W-1:0]   code_sel;
   logic [TMR_W-1:0]    wd_q;
   logic [DW-1:0]       drn_q;
   logic                timeout_q, fin_q;
   logic [CODE_W+2:0]   out_d;

   assign capture_en = (state_q != DONE);

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      assign req[c] = bus.arg[c*CW + CODE_W];
      ext_finish_chan #(
         .CODE_W (CODE_W)
      ) u_chan (
         .CLK        (CLK),
         .RST        (RST),
         .capture_en (capture_en),
         .exit_req   (req[c]),
         .exit_code  (bus.arg[c*CW +: CODE_W]),
         .exited     (exited[c]),
         .code       (codes[c])
      );
   end

   // Trigger sees this cycle's captures as well as the registered ones
   assign exited_now = exited | (req & {NCH{capture_en}});
   assign trigger    = (MODE_ALL != 0) ? (&exited_now) : (|exited_now);
   assign wd_hit     = (TIMEOUT != 0) && (state_q == RUN) && (wd_q == WD_LAST);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Next state: RUN leaves on trigger or watchdog; DRAIN counts out; DONE absorbs
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (trigger || wd_hit) state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
         DRAIN:   if (drn_q == DRAIN_LAST) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   // Watchdog counts RUN cycles and saturates; drain counter idles at 0 outside DRAIN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wd_q  <= '0;
         drn_q <= '0;
      end else begin
         if (state_q == RUN && wd_q != {TMR_W{1'b1}}) wd_q <= wd_q + 1'b1;
         if (state_q == DRAIN) drn_q <= drn_q + 1'b1;
         else                  drn_q <= '0;
      end
   end

   // Timeout flag is set only when the watchdog fires without a competing trigger
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         timeout_q <= 1'b0;
         fin_q     <= 1'b0;
      end else begin
         if (wd_hit && !trigger) timeout_q <= 1'b1;
         fin_q <= (state_d == DONE) && (state_q != DONE);
      end
   end

   // Lowest-index channel with a nonzero code supplies the reported code
   always_comb begin
      fail_any = 1'b0;
      code_sel = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (exited[c] && codes[c] != '0) begin
            fail_any = 1'b1;
            code_sel = codes[c];
         end
      end
   end

   // Status word is held at zero while running
   always_comb begin
      out_d = '0;
      if (state_q != RUN) begin
         out_d[DONE_IDX]     = (state_q == DONE);
         out_d[TMO_IDX]      = timeout_q;
         out_d[FAIL_IDX]     = timeout_q | fail_any;
         out_d[CODE_W-1:0]   = timeout_q ? TO_CODE : code_sel;
      end
   end

   assign bus.out    = out_d;
   assign bus.finish = fin_q;

`ifdef SIMULATION
   // Report the verdict on the finish cycle and end the run
   always @(posedge CLK) begin
      if (fin_q) begin
         if (timeout_q)     $display("%sTIMEOUT%s", ANSI_RED, ANSI_RESET);
         else if (fail_any) $display("%sFAIL (%0d)%s", ANSI_RED, code_sel, ANSI_RESET);
         else               $display("%sPASS%s", ANSI_GREEN, ANSI_RESET);
         $finish;
      end
   end
`endif
endmodule

// File: tb/tb_ext_finish_mc.sv
// Bench for ext_finish_mc: four configurations share one stimulus stream and are checked every
// cycle against a cycle-count model, plus literal checks at the key cycles.
module tb_ext_finish_mc;
   localparam int P_NCH [4] = '{2, 2, 2, 1};
   localparam int P_ALL [4] = '{1, 0, 0, 1};
   localparam int P_DRN [4] = '{4, 4, 4, 0};
   localparam int P_TMO [4] = '{0, 0, 100, 0};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] code0 = 8'h00, code1 = 8'h00;
   int         cur = 0;
   int         n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   ext_finish_mc_if #(.NCH(2), .CODE_W(8)) if_a ();
   ext_finish_mc_if #(.NCH(2), .CODE_W(8)) if_b ();
   ext_finish_mc_if #(.NCH(2), .CODE_W(8)) if_c ();
   ext_finish_mc_if #(.NCH(1), .CODE_W(8)) if_d ();

   assign if_a.arg = {req1, code1, req0, code0};
   assign if_b.arg = {req1, code1, req0, code0};
   assign if_c.arg = {req1, code1, req0, code0};
   assign if_d.arg = {req0, code0};

   ext_finish_mc #(.NCH(2), .CODE_W(8), .MODE_ALL(1), .DRAIN_CYCLES(4), .TIMEOUT(0), .TMR_W(32))
      u_a (.CLK(clk), .RST(rst), .bus(if_a));
   ext_finish_mc #(.NCH(2), .CODE_W(8), .MODE_ALL(0), .DRAIN_CYCLES(4), .TIMEOUT(0), .TMR_W(32))
      u_b (.CLK(clk), .RST(rst), .bus(if_b));
   ext_finish_mc #(.NCH(2), .CODE_W(8), .MODE_ALL(0), .DRAIN_CYCLES(4), .TIMEOUT(100), .TMR_W(32))
      u_c (.CLK(clk), .RST(rst), .bus(if_c));
   ext_finish_mc #(.NCH(1), .CODE_W(8), .MODE_ALL(1), .DRAIN_CYCLES(0), .TIMEOUT(0), .TMR_W(32))
      u_d (.CLK(clk), .RST(rst), .bus(if_d));

   logic [10:0] d_out [4];
   logic        d_fin [4];
   assign d_out[0] = if_a.out;  assign d_fin[0] = if_a.finish;
   assign d_out[1] = if_b.out;  assign d_fin[1] = if_b.finish;
   assign d_out[2] = if_c.out;  assign d_fin[2] = if_c.finish;
   assign d_out[3] = if_d.out;  assign d_fin[3] = if_d.finish;

   // Model: remember which channels exited with what code, the cycle the run ended and why.
   // Everything else follows from the cycle distance to that end point.
   bit         m_ex  [4][2];
   logic [7:0] m_cd  [4][2];
   int         m_end [4];
   bit         m_to  [4];
   int         m_cyc [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic m_reset(input int i);
      for (int c = 0; c < 2; c++) begin
         m_ex[i][c] = 1'b0;
         m_cd[i][c] = 8'h00;
      end
      m_end[i] = -1;
      m_to[i]  = 1'b0;
      m_cyc[i] = 0;
   endtask

   function automatic bit m_done(input int i);
      return (m_end[i] >= 0) && (m_cyc[i] - m_end[i] >= P_DRN[i] + 1);
   endfunction

   function automatic bit m_fin(input int i);
      return (m_end[i] >= 0) && (m_cyc[i] - m_end[i] == P_DRN[i] + 1);
   endfunction

   function automatic logic [10:0] m_out(input int i);
      bit         f = m_to[i];
      bit         found = 1'b0;
      logic [7:0] cd = 8'h00;
      if (m_to[i]) cd = 8'hFF;
      else begin
         for (int c = 0; c < P_NCH[i]; c++) begin
            if (!found && m_ex[i][c] && m_cd[i][c] != 8'h00) begin
               found = 1'b1;
               f     = 1'b1;
               cd    = m_cd[i][c];
            end
         end
      end
      return {m_done(i), m_to[i], f, cd};
   endfunction

   task automatic m_step(input int i);
      bit         rq [2];
      logic [7:0] cq [2];
      bit         all_ex = 1'b1;
      bit         any_ex = 1'b0;
      bit         trig;
      rq[0] = req0; cq[0] = code0;
      rq[1] = req1; cq[1] = code1;
      if (!m_done(i)) begin
         for (int c = 0; c < P_NCH[i]; c++) begin
            if (rq[c] && !m_ex[i][c]) begin
               m_ex[i][c] = 1'b1;
               m_cd[i][c] = cq[c];
            end
         end
      end
      for (int c = 0; c < P_NCH[i]; c++) begin
         all_ex = all_ex & m_ex[i][c];
         any_ex = any_ex | m_ex[i][c];
      end
      trig = (P_ALL[i] != 0) ? all_ex : any_ex;
      if (m_end[i] < 0) begin
         if (trig) m_end[i] = m_cyc[i];
         else if (P_TMO[i] != 0 && m_cyc[i] == P_TMO[i] - 1) begin
            m_end[i] = m_cyc[i];
            m_to[i]  = 1'b1;
         end
      end
      m_cyc[i]++;
   endtask

   // Per-cycle compare against the model, sampled on the falling edge
   initial begin
      for (int i = 0; i < 4; i++) m_reset(i);
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (rst) begin
               m_reset(i);
               check($sformatf("u%0d.out_in_reset", i), 32'(d_out[i]), 32'h0);
               check($sformatf("u%0d.finish_in_reset", i), 32'(d_fin[i]), 32'h0);
            end else begin
               if (m_end[i] < 0)
                  check($sformatf("u%0d.done_run@%0d", i, m_cyc[i]), 32'(d_out[i][10]), 32'h0);
               else
                  check($sformatf("u%0d.out@%0d", i, m_cyc[i]), 32'(d_out[i]), 32'(m_out(i)));
               check($sformatf("u%0d.finish@%0d", i, m_cyc[i]), 32'(d_fin[i]), 32'(m_fin(i)));
               m_step(i);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic goto(input int k);
      while (cur < k) tick();
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req0 = 1'b0; req1 = 1'b0; code0 = 8'h00; code1 = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      cur = 0;
   endtask

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
      check($sformatf("%s@%0d", name, cur), act, exp);
   endtask

   initial begin
      // All-exit mode with a 4-cycle drain
      do_reset();
      for (int i = 0; i < 4; i++) pin($sformatf("u%0d.reset_out", i), 32'(d_out[i]), 32'h0);
      goto(10); req0 = 1'b1; code0 = 8'h00; tick(); req0 = 1'b0;
      goto(20); req1 = 1'b1; code1 = 8'h00; tick(); req1 = 1'b0;
      pin("a.out_drain", 32'(if_a.out), 32'h000);
      goto(24); pin("a.finish_early", 32'(if_a.finish), 32'h0);
      goto(25); pin("a.finish", 32'(if_a.finish), 32'h1);
      pin("a.out_pass", 32'(if_a.out), 32'h400);
      goto(26); pin("a.finish_once", 32'(if_a.finish), 32'h0);
      goto(30);

      // First-exit mode, later lower-index exit during drain takes the code
      do_reset();
      goto(5); req1 = 1'b1; code1 = 8'h03; tick(); req1 = 1'b0;
      req0 = 1'b1; code0 = 8'h07;
      pin("b.out_drain_code3", 32'(if_b.out), 32'h103);
      tick(); req0 = 1'b0;
      pin("b.out_drain_code7", 32'(if_b.out), 32'h107);
      goto(10); pin("b.finish", 32'(if_b.finish), 32'h1);
      pin("b.out_fail7", 32'(if_b.out), 32'h507);
      goto(11); pin("a.out_fail7", 32'(if_a.out), 32'h507);
      goto(15);

      // Same-cycle requests, then an ignored repeat
      do_reset();
      goto(8); req0 = 1'b1; code0 = 8'h00; req1 = 1'b1; code1 = 8'h09; tick();
      req0 = 1'b0; code1 = 8'h02;
      pin("b.out_same_cycle", 32'(if_b.out), 32'h109);
      tick(); req1 = 1'b0;
      pin("b.out_repeat_ignored", 32'(if_b.out), 32'h109);
      goto(13); pin("a.out_code9", 32'(if_a.out), 32'h509);
      goto(16);

      // Watchdog expiry with no exits
      do_reset();
      goto(99); pin("c.done_before_timeout", 32'(if_c.out[10]), 32'h0);
      goto(100); pin("c.out_timeout_drain", 32'(if_c.out), 32'h3FF);
      goto(104); pin("c.finish_timeout", 32'(if_c.finish), 32'h1);
      pin("c.out_timeout_done", 32'(if_c.out), 32'h7FF);
      goto(105); pin("c.out_timeout_frozen", 32'(if_c.out), 32'h7FF);
      goto(108);

      // Exit on the last watchdog cycle: the trigger wins
      do_reset();
      goto(99); req0 = 1'b1; code0 = 8'h00; tick(); req0 = 1'b0;
      pin("c.out_tie_drain", 32'(if_c.out), 32'h000);
      goto(104); pin("c.out_tie_done", 32'(if_c.out), 32'h400);
      goto(106);

      // Asynchronous reset mid-drain, then a clean run
      do_reset();
      goto(3); req0 = 1'b1; code0 = 8'h05; tick(); req0 = 1'b0;
      goto(6); pin("b.out_before_rst", 32'(if_b.out), 32'h105);
      #1; rst = 1'b1; #1;
      pin("b.out_async_rst", 32'(if_b.out), 32'h0);
      pin("d.out_async_rst", 32'(if_d.out), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      cur = 0;
      goto(3); req0 = 1'b1; code0 = 8'h00; pin("d.finish_before", 32'(if_d.finish), 32'h0);
      tick(); req0 = 1'b0;
      pin("d.finish_zero_drain", 32'(if_d.finish), 32'h1);
      pin("d.out_zero_drain", 32'(if_d.out), 32'h400);
      goto(5); pin("d.finish_once", 32'(if_d.finish), 32'h0);
      pin("d.done_held", 32'(if_d.out[10]), 32'h1);
      goto(8); pin("b.finish_after_rst", 32'(if_b.finish), 32'h1);
      pin("b.out_after_rst", 32'(if_b.out), 32'h400);
      goto(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
